// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: point-RAM, host and DAC signals of the vector draw sequencer
//   drawing      host -> seq   frame ready in the read-side buffer
//   num_points   host -> seq   points in that frame
//   point        RAM  -> seq   {z, x[11:0], y[11:0]}, one cycle after read_address
//   read_address seq  -> RAM   point RAM read address
//   done_drawing seq  -> host  one-cycle pulse at frame end
//   x, y, z      seq  -> DAC   registered coordinates and beam enable
//   dac_strobe   seq  -> DAC   one-cycle pulse, x/y/z valid
//   dac_ready    DAC  -> seq   DAC can accept a strobe this cycle
//   busy         seq  -> host  sequencer not idle
interface draw_sequencer_if #(parameter int index_bits = 11);
   logic                  drawing;
   logic [index_bits-1:0] num_points;
   logic [24:0]           point;
   logic [index_bits-1:0] read_address;
   logic                  done_drawing;
   logic [11:0]           x;
   logic [11:0]           y;
   logic                  z;
   logic                  dac_strobe;
   logic                  dac_ready;
   logic                  busy;
   modport master (
      input  drawing, num_points, point, dac_ready,
      output read_address, done_drawing, x, y, z, dac_strobe, busy
   );
   modport slave (
      output drawing, num_points, point, dac_ready,
      input  read_address, done_drawing, x, y, z, dac_strobe, busy
   );
endinterface

// File: rtl/draw_sequencer.sv
// draw_sequencer: walks a point RAM frame and writes each point to a vector DAC with a per-point dwell
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    draw_sequencer_if.master (RAM read port, host handshake, DAC strobe/ready)
// Optional feature macro DRAW_SEQ_PARK_EN: after the last point (or an empty frame) the beam is
// parked at the screen centre (800,800) blanked, with a blank dwell, before DONE.
module draw_sequencer #(
   parameter int index_bits  = 11,
   parameter int lit_dwell   = 64,
   parameter int blank_dwell = 16
) (
   input logic              clk,
   input logic              reset,
   draw_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, DWELL, DONE, WAIT_LOW} state_t;
   state_t                state;
   logic [index_bits-1:0] frame_len;
   logic [15:0]           dwell_cnt;
   logic [24:0]           pending;
   logic                  last;
`ifdef DRAW_SEQ_PARK_EN
   localparam logic [24:0] park_point = {1'b0, 12'h800, 12'h800};
   logic                  parking;
`endif
   assign last = bus.read_address == frame_len - index_bits'(1);
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         bus.read_address <= '0;
         frame_len        <= '0;
         dwell_cnt        <= '0;
         pending          <= '0;
         bus.x            <= '0;
         bus.y            <= '0;
         bus.z            <= 1'b0;
         bus.dac_strobe   <= 1'b0;
         bus.done_drawing <= 1'b0;
         bus.busy         <= 1'b0;
`ifdef DRAW_SEQ_PARK_EN
         parking          <= 1'b0;
`endif
      end else begin
         bus.dac_strobe   <= 1'b0;
         bus.done_drawing <= 1'b0;
         case (state)
            IDLE: if (bus.drawing) begin
               frame_len        <= bus.num_points;
               bus.read_address <= '0;
               bus.busy         <= 1'b1;
`ifdef DRAW_SEQ_PARK_EN
               parking          <= bus.num_points == '0;
               pending          <= park_point;
               state            <= bus.num_points == '0 ? WRITE : FETCH;
`else
               state            <= bus.num_points == '0 ? DONE : FETCH;
`endif
            end
            // RAM output for the new address is only valid one cycle later
            FETCH: state <= LATCH;
            LATCH: begin
               pending <= bus.point;
               state   <= WRITE;
            end
            WRITE: if (bus.dac_ready) begin
               bus.x          <= pending[23:12];
               bus.y          <= pending[11:0];
               bus.z          <= pending[24];
               bus.dac_strobe <= 1'b1;
               // DWELL lasts exactly the dwell count, so load count-1 and leave at zero
               dwell_cnt      <= pending[24] ? 16'(lit_dwell - 1) : 16'(blank_dwell - 1);
               state          <= DWELL;
            end
            DWELL: if (dwell_cnt != '0)
               dwell_cnt <= dwell_cnt - 16'd1;
`ifdef DRAW_SEQ_PARK_EN
            else if (parking)
               state <= DONE;
            else if (last) begin
               pending <= park_point;
               parking <= 1'b1;
               state   <= WRITE;
            end
`else
            else if (last)
               state <= DONE;
`endif
            else begin
               bus.read_address <= bus.read_address + 1'b1;
               state            <= FETCH;
            end
            DONE: begin
               bus.z            <= 1'b0;
               bus.done_drawing <= 1'b1;
               state            <= WAIT_LOW;
            end
            // a drawing level left high after the frame must not redraw it
            WAIT_LOW: if (!bus.drawing) begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter index_bits, default 11: width of point address and point count.
REQ-002 Parameter lit_dwell, default 64: hold cycles after a DAC write of a lit point (z=1); legal range 1..65535.
REQ-003 Parameter blank_dwell, default 16: hold cycles after a DAC write of a blanked point (z=0); legal range 1..65535.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 drawing  in  1  high = a complete frame is ready in the read-side point buffer.
REQ-007 num_points  in  index_bits  number of valid points in the read-side buffer.
REQ-008 point  in  25  RAM data: [24] brightness, [23:12] x, [11:0] y; valid one cycle after read_address changes.
REQ-009 read_address  out  index_bits  point RAM read address.
REQ-010 done_drawing  out  1  one-cycle pulse: frame fully drawn.
REQ-011 x, y  out  12 each  DAC coordinates, registered.
REQ-012 z  out  1  beam enable, registered.
REQ-013 dac_strobe  out  1  one-cycle pulse: x/y/z valid for the DAC driver.
REQ-014 dac_ready  in  1  DAC driver can accept a strobe this cycle.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, FETCH, LATCH, WRITE, DWELL, DONE, WAIT_LOW.
REQ-017 IDLE: when drawing=1, latch num_points into frame_len, set read_address=0, go FETCH.
REQ-018 IDLE with drawing=1 and num_points=0: go DONE directly; no DAC write occurs.
REQ-019 FETCH lasts exactly one cycle to cover RAM read latency; then go LATCH.
REQ-020 LATCH: register point[24], point[23:12] and point[11:0] into a pending point; go WRITE.
REQ-021 WRITE: hold while dac_ready=0; on the first cycle with dac_ready=1, load x/y/z from the pending point, pulse dac_strobe for one cycle, and go DWELL.
REQ-022 Exactly one dac_strobe per point.
REQ-023 DWELL: count lit_dwell cycles if z=1, else blank_dwell cycles, counting from the cycle after the strobe.
REQ-024 At dwell end: if read_address = frame_len-1, go DONE; otherwise increment read_address and go FETCH.
REQ-025 Per-point period = 3 + dwell + (cycles dac_ready was low).
REQ-026 DONE: force z=0, pulse done_drawing for one cycle, then go WAIT_LOW.
REQ-027 WAIT_LOW: stay until drawing=0, then go IDLE. This prevents a stale drawing level from restarting the same frame.
REQ-028 A drop of drawing mid-frame is ignored; the frame completes normally.
REQ-029 num_points changes after frame start are ignored; frame_len is used.
REQ-030 read_address and frame_len are index_bits wide; read_address never exceeds frame_len-1.
REQ-031 Maximum frame length is 2^index_bits-1 points.
REQ-032 x/y hold their last written values between strobes and after DONE.

Reset
REQ-033 While reset=1, on the clock edge:
- state = IDLE;
- read_address, frame_len, dwell counter = 0;
- x = 0, y = 0, z = 0;
- dac_strobe = 0, done_drawing = 0, busy = 0.
REQ-034 Reset mid-frame aborts immediately: no further strobe, and no done_drawing pulse.

Configuration
REQ-035 Macro DRAW_SEQ_PARK_EN.
REQ-036 DRAW_SEQ_PARK_EN defined: after the last point's dwell (and for an empty frame), perform one extra WRITE of x=12'h800, y=12'h800, z=0 (same dac_ready handshake), then blank_dwell, then go DONE.
REQ-037 DRAW_SEQ_PARK_EN undefined: no park write; DONE only forces z=0 and x/y hold.

Verification
REQ-038 Reset mid-DWELL of point 2 in a 5-point frame -> next cycle: state IDLE, outputs zero, busy=0, no done_drawing pulse.
REQ-039 drawing=1, num_points=3, RAM {0x1_000_000, 0x0_FFF_FFF, 0x1_123_456}, dac_ready=1, lit_dwell=4, blank_dwell=2 -> strobes with (x,y,z) = (000,000,1), (FFF,FFF,0), (123,456,1), spaced 7 and 5 cycles; one done_drawing pulse; z=0 afterwards.
REQ-040 num_points=0 with drawing=1 -> done_drawing within 2 cycles; no dac_strobe (macro undefined), or exactly one park strobe at (800,800,0) (macro defined).
REQ-041 dac_ready held low for 10 cycles in WRITE -> dac_strobe delayed exactly 10 cycles; x/y/z unchanged until the strobe.
REQ-042 drawing stays high for 5 cycles after the done_drawing pulse -> no new FETCH until drawing=0; drawing re-raised later -> new frame starts from address 0.
REQ-043 Frame of 2047 points with index_bits=11 -> read_address sweeps 0..2046 with no wrap; exactly 2047 strobes.
